// File: rtl/regfile_writeback_if.sv
// Bundle of result-source, decode-check and register-file write-port signals
// for the write-back stage.
interface regfile_writeback_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INDEX = 5,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             alu_valid_in;
  logic [INDEX-1:0] alu_rd_in;
  logic [WIDTH-1:0] alu_data_in;
  logic             alu_stall_out;
  logic             mem_valid_in;
  logic             mem_ready_out;
  logic [INDEX-1:0] mem_rd_in;
  logic [WIDTH-1:0] mem_data_in;
  logic             issue_in;
  logic [INDEX-1:0] issue_rd_in;
  logic [INDEX-1:0] check_rs1_in;
  logic [INDEX-1:0] check_rs2_in;
  logic             busy_rs1_out;
  logic             busy_rs2_out;
  logic             we_out;
  logic [INDEX-1:0] address_w_out;
  logic [WIDTH-1:0] data_w_out;
  logic [CW-1:0]    fifo_count_out;

  // Upstream side: result producers, decode and the register file.
  modport master (
    output alu_valid_in, alu_rd_in, alu_data_in,
    output mem_valid_in, mem_rd_in, mem_data_in,
    output issue_in, issue_rd_in, check_rs1_in, check_rs2_in,
    input  alu_stall_out, mem_ready_out, busy_rs1_out, busy_rs2_out,
    input  we_out, address_w_out, data_w_out, fifo_count_out
  );

  // Write-back stage side.
  modport slave (
    input  alu_valid_in, alu_rd_in, alu_data_in,
    input  mem_valid_in, mem_rd_in, mem_data_in,
    input  issue_in, issue_rd_in, check_rs1_in, check_rs2_in,
    output alu_stall_out, mem_ready_out, busy_rs1_out, busy_rs2_out,
    output we_out, address_w_out, data_w_out, fifo_count_out
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-back: merges single-cycle ALU results and queued
// long-latency results onto one write port, and tracks pending destinations.
module regfile_writeback #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INDEX = 5,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  regfile_writeback_if.slave bus
);
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NREG = 2 ** INDEX;

  typedef enum logic {NORMAL, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [INDEX-1:0] fifo_rd_q   [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [NREG-1:0]  pend_q, pend_d;
  logic             we_q, we_d;
  logic [INDEX-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             push, pop, sel_alu;
  logic [INDEX-1:0] head_rd;
  logic [WIDTH-1:0] head_data;

  assign head_rd   = fifo_rd_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // DRAIN is held exactly while the registered count equals DEPTH, so the
  // ready/stall outputs come straight from state and never from mem_valid_in.
  assign bus.mem_ready_out  = (state_q == NORMAL) & ~rst_in;
  assign bus.alu_stall_out  = (state_q == DRAIN) & ~rst_in;
  assign bus.busy_rs1_out   = pend_q[bus.check_rs1_in];
  assign bus.busy_rs2_out   = pend_q[bus.check_rs2_in];
  assign bus.we_out         = we_q;
  assign bus.address_w_out  = addr_q;
  assign bus.data_w_out     = data_q;
  assign bus.fifo_count_out = count_q;

  // Arbitration, FIFO occupancy, scoreboard and write-port next state.
  always_comb begin
    sel_alu = 1'b0;
    pop     = 1'b0;
    if (state_q == NORMAL) begin
      if (bus.alu_valid_in)       sel_alu = 1'b1;
      else if (count_q != '0)     pop     = 1'b1;
    end else begin
      pop = 1'b1;
    end
    push    = bus.mem_valid_in & bus.mem_ready_out;
    count_d = count_q + CW'(push) - CW'(pop);
    state_d = (count_d == CW'(DEPTH)) ? DRAIN : NORMAL;

    // Clear on pop first so a same-cycle issue to the same rd wins.
    pend_d = pend_q;
    if (pop)          pend_d[head_rd]         = 1'b0;
    if (bus.issue_in) pend_d[bus.issue_rd_in] = 1'b1;
    pend_d[0] = 1'b0;

    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (sel_alu) begin
      if (bus.alu_rd_in != '0) begin
        we_d   = 1'b1;
        addr_d = bus.alu_rd_in;
        data_d = bus.alu_data_in;
      end
    end else if (pop && head_rd != '0) begin
      we_d   = 1'b1;
      addr_d = head_rd;
      data_d = head_data;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.mem_rd_in;
      fifo_data_q[wr_ptr_q] <= bus.mem_data_in;
    end
  end

  // Arbiter state, pointers, scoreboard and registered write port.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= NORMAL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end
endmodule
